// File: rtl/zcu216_duc_nco.sv
// Digital up-converter: rotates SPC packed I/Q lanes by a programmable NCO, 4-cycle fixed latency.
// Optional phase dithering is enabled by defining ZCU216_DUC_DITHER_EN.
module zcu216_duc_nco #(
  parameter int SPC            = 8,
  parameter int IQ_WIDTH       = 14,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int COEF_WIDTH     = 16,
  parameter int OUT_WIDTH      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic [32*SPC-1:0]        i_qi,
  input  logic [PHASE_WIDTH-1:0]   i_phase_inc,
  input  logic [PHASE_WIDTH-1:0]   i_phase_off,
  input  logic                     i_cfg_load,
  input  logic                     i_phase_sync,
  input  logic                     i_sat_clr,
  output logic                     o_valid,
  output logic [OUT_WIDTH*SPC-1:0] o_rf,
  output logic                     o_sat
);

  localparam int  PW       = IQ_WIDTH + COEF_WIDTH + 1;
  localparam int  S        = IQ_WIDTH + COEF_WIDTH - 1 - OUT_WIDTH;
  localparam int  LUT_SIZE = 2 ** LUT_ADDR_WIDTH;
  localparam real PI       = 3.14159265358979323846;
  localparam logic signed [PW:0] HALF = (PW+1)'(2 ** (S - 1));
  localparam logic signed [PW:0] MAXV = (PW+1)'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [PW:0] MINV = -(PW+1)'(2 ** (OUT_WIDTH - 1));

  function automatic logic signed [COEF_WIDTH-1:0] tab_val(input int j, input bit is_sin);
    real a;
    real v;
    a = 2.0 * PI * j / (2.0 ** LUT_ADDR_WIDTH);
    v = ((2.0 ** (COEF_WIDTH - 1)) - 1.0) * (is_sin ? $sin(a) : $cos(a));
    return COEF_WIDTH'((v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v));
  endfunction

  logic signed [COEF_WIDTH-1:0] cos_rom [LUT_SIZE];
  logic signed [COEF_WIDTH-1:0] sin_rom [LUT_SIZE];

  for (genvar j = 0; j < LUT_SIZE; j++) begin : g_rom
    assign cos_rom[j] = tab_val(j, 1'b0);
    assign sin_rom[j] = tab_val(j, 1'b1);
  end

  logic [PHASE_WIDTH-1:0]    inc_r, off_r, acc, base, dith;
  logic [PHASE_WIDTH-1:0]    ph_c  [SPC];
  logic [LUT_ADDR_WIDTH-1:0] idx_c [SPC];

  logic                         v1, v2, v3;
  logic [LUT_ADDR_WIDTH-1:0]    idx1 [SPC];
  logic signed [IQ_WIDTH-1:0]   i1 [SPC], q1 [SPC], i2 [SPC], q2 [SPC];
  logic signed [COEF_WIDTH-1:0] cos2 [SPC], sin2 [SPC];
  logic signed [PW-1:0]         prod3 [SPC];

  logic signed [PW:0]           rnd_c [SPC];
  logic signed [OUT_WIDTH-1:0]  sat_c [SPC];
  logic [SPC-1:0]               ovf_c;

`ifdef ZCU216_DUC_DITHER_EN
  localparam int DITH_BITS = ((PHASE_WIDTH - LUT_ADDR_WIDTH) < 16) ? (PHASE_WIDTH - LUT_ADDR_WIDTH) : 16;
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; steps only on accepted beats
  always_ff @(posedge i_clk) begin
    if (!i_rstn)
      lfsr <= 16'hACE1;
    else if (i_valid)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_comb begin
    dith = '0;
    dith[DITH_BITS-1:0] = lfsr[DITH_BITS-1:0];
  end
`else
  assign dith = '0;
`endif

  // Stage 1 combinational: lane phases from the beat's base phase
  always_comb begin
    base = i_phase_sync ? '0 : acc;
    for (int k = 0; k < SPC; k++) begin
      ph_c[k]  = base + PHASE_WIDTH'(k) * inc_r + off_r + dith;
      idx_c[k] = ph_c[k][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH];
    end
  end

  always_comb begin
    ovf_c = '0;
    for (int k = 0; k < SPC; k++) begin
      rnd_c[k] = ((PW+1)'(prod3[k]) + HALF) >>> S;
      sat_c[k] = rnd_c[k][OUT_WIDTH-1:0];
      if (rnd_c[k] > MAXV) begin
        sat_c[k] = MAXV[OUT_WIDTH-1:0];
        ovf_c[k] = 1'b1;
      end else if (rnd_c[k] < MINV) begin
        sat_c[k] = MINV[OUT_WIDTH-1:0];
        ovf_c[k] = 1'b1;
      end
    end
  end

  // Control state: config, accumulator, valid pipe, outputs
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      inc_r   <= '0;
      off_r   <= '0;
      acc     <= '0;
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      o_valid <= 1'b0;
      o_rf    <= '0;
      o_sat   <= 1'b0;
    end else begin
      if (i_cfg_load) begin
        inc_r <= i_phase_inc;
        off_r <= i_phase_off;
      end
      if (i_valid)
        acc <= base + PHASE_WIDTH'(SPC) * inc_r;
      else if (i_phase_sync)
        acc <= '0;
      v1      <= i_valid;
      v2      <= v1;
      v3      <= v2;
      o_valid <= v3;
      if (v3) begin
        for (int k = 0; k < SPC; k++)
          o_rf[OUT_WIDTH*k +: OUT_WIDTH] <= sat_c[k];
      end
      // a fresh saturation outranks a simultaneous clear
      if (v3 && (|ovf_c))
        o_sat <= 1'b1;
      else if (i_sat_clr)
        o_sat <= 1'b0;
    end
  end

  // Data pipeline: phase index -> table read -> multiply
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < SPC; k++) begin
      idx1[k]  <= idx_c[k];
      i1[k]    <= i_qi[32*k +: IQ_WIDTH];
      q1[k]    <= i_qi[32*k+16 +: IQ_WIDTH];
      cos2[k]  <= cos_rom[idx1[k]];
      sin2[k]  <= sin_rom[idx1[k]];
      i2[k]    <= i1[k];
      q2[k]    <= q1[k];
      prod3[k] <= PW'(i2[k]) * PW'(cos2[k]) - PW'(q2[k]) * PW'(sin2[k]);
    end
  end

endmodule
